// File: rtl/quant_sched_pkg.sv
// Shared types and constants for the macroblock quantizer scheduler:
// FSM state encoding, quantizer matrix selects, block-count constants and
// the block-index helpers used to walk a macroblock.
package quant_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_QUANT,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [1:0] Q_SEL_Y1 = 2'd0;
  localparam logic [1:0] Q_SEL_Y2 = 2'd1;
  localparam logic [1:0] Q_SEL_UV = 2'd2;

  localparam int NUM_Y  = 16;
  localparam int NUM_UV = 8;

  localparam logic [4:0] IDX_Y2   = 5'd24;
  localparam logic [4:0] IDX_LAST = 5'(NUM_Y + NUM_UV - 1);

  // Matrix select implied by a block index: 0..15 luma, 16..23 chroma, 24 Y2.
  function automatic logic [1:0] idx_to_sel(input logic [4:0] idx);
    if (idx == IDX_Y2) begin
      return Q_SEL_Y2;
    end else if (idx < 5'(NUM_Y)) begin
      return Q_SEL_Y1;
    end else begin
      return Q_SEL_UV;
    end
  endfunction

  // Successor in the walk order; the Y2 block (when present) is followed by block 0.
  function automatic logic [4:0] next_idx(input logic [4:0] idx);
    if (idx == IDX_Y2) begin
      return 5'd0;
    end else begin
      return idx + 5'd1;
    end
  endfunction

endpackage

// File: rtl/quant_sched_wdog.sv
// Quantizer-done watchdog: loadable down-counter with clear. Loaded with
// WD_MAX-1 when the quantizer is started, counts while enabled, and flags
// expiry during the enabled cycle in which it has reached zero, so the
// enabled window lasts WD_MAX cycles before expiry ends it.
module quant_sched_wdog #(
  parameter int WD_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (WD_MAX > 2) ? $clog2(WD_MAX) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear dominates load, load dominates decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/quant_mb_sched.sv
// Macroblock scheduler for the shared 4x4 quantizer. Walks the 24 (or 25)
// transform blocks of a macroblock through FETCH/QUANT/WAIT/WRITE, selects
// the quantizer matrix per block, guards the quantizer with a watchdog and
// collects the per-block non-zero flags into nz_mask.
// Build option: define QUANT_Y2_EN to sequence the Y2 DC block (index 24,
// matrix select 1) ahead of the luma blocks and make nz_mask[24] live.
module quant_mb_sched
  import quant_sched_pkg::*;
#(
  parameter int WD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mb_start,
  output logic        mb_busy,
  output logic        mb_done,
  output logic [24:0] nz_mask,
  output logic        err,
  output logic        blk_req,
  output logic [4:0]  blk_idx,
  input  logic        blk_vld,
  output logic        q_start,
  output logic [1:0]  q_sel,
  input  logic        q_done,
  input  logic        q_nz,
  output logic        out_wr,
  input  logic        out_rdy
);

`ifdef QUANT_Y2_EN
  localparam logic [4:0] FIRST_IDX = IDX_Y2;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  sel_q, sel_d;
  logic [24:0] mask_q, mask_d;
  logic        err_q, err_d;

  logic busy_q, done_q, req_q, qstart_q, wr_q;

  logic wd_clr, wd_load, wd_en, wd_expire;

  // The watchdog is armed on the single QUANT cycle and runs only in WAIT.
  assign wd_clr  = (state_q == ST_IDLE);
  assign wd_load = (state_q == ST_QUANT);
  assign wd_en   = (state_q == ST_WAIT);

  quant_sched_wdog #(
    .WD_MAX (WD_MAX)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .load_i   (wd_load),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Next-state, block index/select, mask and error update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mb_start) begin
          state_d = ST_FETCH;
          idx_d   = FIRST_IDX;
          sel_d   = idx_to_sel(FIRST_IDX);
          mask_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (blk_vld) begin
          state_d = ST_QUANT;
        end
      end
      ST_QUANT: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (q_done) begin
          mask_d[idx_q] = q_nz;
          state_d       = ST_WRITE;
        end else if (wd_expire) begin
          // Block is abandoned with its mask bit left clear.
          err_d   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (out_rdy) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            idx_d   = next_idx(idx_q);
            sel_d   = idx_to_sel(next_idx(idx_q));
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifndef QUANT_Y2_EN
    mask_d[IDX_Y2] = 1'b0;
`endif
  end

  // State, datapath-control registers and strobes decoded from the next state,
  // so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      sel_q    <= Q_SEL_Y1;
      mask_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      qstart_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      req_q    <= (state_d == ST_FETCH);
      qstart_q <= (state_d == ST_QUANT);
      wr_q     <= (state_d == ST_WRITE);
    end
  end

  assign mb_busy = busy_q;
  assign mb_done = done_q;
  assign nz_mask = mask_q;
  assign err     = err_q;
  assign blk_req = req_q;
  assign blk_idx = idx_q;
  assign q_start = qstart_q;
  assign q_sel   = sel_q;
  assign out_wr  = wr_q;

endmodule

// File: tb/tb_quant_mb_sched.sv
// Scoreboard bench for quant_mb_sched. Directed runs push the expected block
// sequence and per-macroblock results into queues; a monitor pops and
// compares on every q_start and mb_done. Also builds with QUANT_Y2_EN.
module tb_quant_mb_sched;

`ifdef QUANT_Y2_EN
  localparam int EXTRA = 5;
  localparam int NBLK  = 25;
  localparam logic [24:0] MASK_RUN1 = 25'h1020008;
`else
  localparam int EXTRA = 0;
  localparam int NBLK  = 24;
  localparam logic [24:0] MASK_RUN1 = 25'h0020008;
`endif

  logic        clk;
  logic        rst;
  logic        mb_start;
  logic        mb_busy;
  logic        mb_done;
  logic [24:0] nz_mask;
  logic        err;
  logic        blk_req;
  logic [4:0]  blk_idx;
  logic        blk_vld;
  logic        q_start;
  logic [1:0]  q_sel;
  logic        q_done;
  logic        q_nz;
  logic        out_wr;
  logic        out_rdy;

  quant_mb_sched dut (
    .clk      (clk),
    .rst      (rst),
    .mb_start (mb_start),
    .mb_busy  (mb_busy),
    .mb_done  (mb_done),
    .nz_mask  (nz_mask),
    .err      (err),
    .blk_req  (blk_req),
    .blk_idx  (blk_idx),
    .blk_vld  (blk_vld),
    .q_start  (q_start),
    .q_sel    (q_sel),
    .q_done   (q_done),
    .q_nz     (q_nz),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at cycle %0d", nm, cyc);
  endtask

  // Scoreboard queues
  typedef struct packed {
    logic [4:0] idx;
    logic [1:0] sel;
  } blk_exp_t;

  typedef struct packed {
    int          lat;
    logic [24:0] mask;
    logic        err;
    int          nstart;
  } mb_exp_t;

  blk_exp_t blk_q[$];
  mb_exp_t  mb_q[$];
  int       start_cyc = 0;

  // Test knobs for the quantizer model and the backpressure process
  logic [24:0] nz_set = '0;
  logic [4:0]  drop_idx = 5'd31;
  logic [4:0]  wr_stall_idx = 5'd31;
  logic [4:0]  vld_stall_idx = 5'd31;

  // Quantizer model: q_done two cycles after q_start, q_nz from nz_set.
  logic p0_v = 1'b0, p0_nz = 1'b0, p1_v = 1'b0, p1_nz = 1'b0;
  always @(negedge clk) begin
    q_done = p1_v;
    q_nz   = p1_v & p1_nz;
    p1_v   = p0_v;
    p1_nz  = p0_nz;
    p0_v   = (q_start === 1'b1) && (blk_idx != drop_idx);
    p0_nz  = nz_set[blk_idx];
  end

  // Backpressure: stall out_rdy 4 cycles / blk_vld 3 cycles on selected blocks.
  int   wr_stall = 0, vld_stall = 0;
  logic prev_wr = 1'b0, prev_req = 1'b0;
  always @(negedge clk) begin
    if (wr_stall > 0) begin
      wr_stall--;
      if (wr_stall == 0) out_rdy = 1'b1;
    end else if (out_wr === 1'b1 && !prev_wr && blk_idx == wr_stall_idx) begin
      out_rdy  = 1'b0;
      wr_stall = 4;
    end
    if (vld_stall > 0) begin
      vld_stall--;
      if (vld_stall == 0) blk_vld = 1'b1;
    end else if (blk_req === 1'b1 && !prev_req && blk_idx == vld_stall_idx) begin
      blk_vld   = 1'b0;
      vld_stall = 3;
    end
    prev_wr  = (out_wr === 1'b1);
    prev_req = (blk_req === 1'b1);
  end

  // Monitor: compares block sequence, per-macroblock results and index stability.
  int         qstart_cnt = 0;
  int         stab_viol = 0;
  logic       m_prev_busy = 1'b0, m_prev_req = 1'b0;
  logic [4:0] m_prev_idx = '0;
  logic [1:0] m_prev_sel = '0;
  always @(negedge clk) begin
    blk_exp_t be;
    mb_exp_t  me;
    if (mb_busy === 1'b1 && !m_prev_busy) begin
      qstart_cnt = 0;
      stab_viol  = 0;
    end
    if (mb_busy === 1'b1 && m_prev_busy && !(blk_req === 1'b1 && !m_prev_req) &&
        (blk_idx != m_prev_idx || q_sel != m_prev_sel)) begin
      stab_viol++;
    end
    if (q_start === 1'b1) begin
      qstart_cnt++;
      if (blk_q.size() == 0) begin
        fail_timeout("blk_seq_unexpected_q_start");
      end else begin
        be = blk_q.pop_front();
        chk("blk_seq", {25'd0, blk_idx, q_sel}, {25'd0, be.idx, be.sel});
      end
    end
    if (mb_done === 1'b1) begin
      if (mb_q.size() == 0) begin
        fail_timeout("mb_done_unexpected");
      end else begin
        me = mb_q.pop_front();
        chk("mb_latency", cyc - start_cyc, me.lat);
        chk("nz_mask", {7'd0, nz_mask}, {7'd0, me.mask});
        chk("err", {31'd0, err}, {31'd0, me.err});
        chk("q_start_count", qstart_cnt, me.nstart);
        chk("idx_stable", stab_viol, 0);
      end
    end
    m_prev_busy = (mb_busy === 1'b1);
    m_prev_req  = (blk_req === 1'b1);
    m_prev_idx  = blk_idx;
    m_prev_sel  = q_sel;
  end

  // Stimulus helpers
  task automatic push_blocks(input int n_std);
`ifdef QUANT_Y2_EN
    blk_q.push_back('{idx: 5'd24, sel: 2'd1});
`endif
    for (int i = 0; i < n_std; i++) begin
      blk_q.push_back('{idx: 5'(i), sel: (i < 16) ? 2'd0 : 2'd2});
    end
  endtask

  task automatic push_mb(input int lat, input logic [24:0] mask, input logic e);
    mb_q.push_back('{lat: lat, mask: mask, err: e, nstart: NBLK});
  endtask

  task automatic start_mb();
    @(negedge clk);
    mb_start  = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    mb_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mb_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout(nm);
  endtask

  task automatic wait_blk(input logic [4:0] idx, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_start === 1'b1 && blk_idx == idx) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout(nm);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  {31'd0, mb_busy}, 32'd0);
    chk({nm, "_done"},  {31'd0, mb_done}, 32'd0);
    chk({nm, "_mask"},  {7'd0, nz_mask},  32'd0);
    chk({nm, "_err"},   {31'd0, err},     32'd0);
    chk({nm, "_req"},   {31'd0, blk_req}, 32'd0);
    chk({nm, "_idx"},   {27'd0, blk_idx}, 32'd0);
    chk({nm, "_qs"},    {31'd0, q_start}, 32'd0);
    chk({nm, "_sel"},   {30'd0, q_sel},   32'd0);
    chk({nm, "_wr"},    {31'd0, out_wr},  32'd0);
  endtask

  initial begin
    int c0;
    bit ok;
    rst = 1'b1; mb_start = 1'b0; blk_vld = 1'b1; out_rdy = 1'b1;
    q_done = 1'b0; q_nz = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Run 1: nominal, plus mb_start while busy and while in DONE.
    nz_set = 25'h1020008;
    push_blocks(24);
    push_mb(121 + EXTRA, MASK_RUN1, 1'b0);
    start_mb();
    repeat (40) @(negedge clk);
    mb_start = 1'b1;
    @(negedge clk);
    mb_start = 1'b0;
    wait_done("run1_done");
    mb_start = 1'b1;
    @(negedge clk);
    mb_start = 1'b0;
    chk("start_in_done_busy", {31'd0, mb_busy}, 32'd0);
    @(negedge clk);
    chk("start_in_done_req", {31'd0, blk_req}, 32'd0);
    chk("mask_hold", {7'd0, nz_mask}, {7'd0, MASK_RUN1});

    // Run 2: backpressure on blocks 5 (out_rdy) and 20 (blk_vld).
    nz_set = 25'h0800001;
    wr_stall_idx = 5'd5;
    vld_stall_idx = 5'd20;
    push_blocks(24);
    push_mb(128 + EXTRA, 25'h0800001, 1'b0);
    start_mb();
    wait_done("run2_done");
    wr_stall_idx = 5'd31;
    vld_stall_idx = 5'd31;

    // Run 3: quantizer never answers on block 9.
    nz_set = 25'h0000600;
    drop_idx = 5'd9;
    push_blocks(24);
    push_mb(134 + EXTRA, 25'h0000400, 1'b1);
    start_mb();
    wait_blk(5'd9, "run3_blk9");
    chk("wd_err_before", {31'd0, err}, 32'd0);
    c0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_wr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("run3_write9");
    chk("wd_cycles", cyc - c0, 16);
    chk("wd_err_set", {31'd0, err}, 32'd1);
    chk("wd_mask9", {31'd0, nz_mask[9]}, 32'd0);
    wait_done("run3_done");
    drop_idx = 5'd31;

    // Run 4: reset during WAIT of block 12; late q_done must be ignored.
    nz_set = 25'h0001004;
    push_blocks(13);
    start_mb();
    chk("start_clears_err", {31'd0, err}, 32'd0);
    chk("start_clears_mask", {7'd0, nz_mask}, 32'd0);
    wait_blk(5'd12, "run4_blk12");
    @(negedge clk);
    chk("pre_rst_mask", {7'd0, nz_mask}, 32'h4);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_mask", {7'd0, nz_mask}, 32'd0);
    chk("post_rst_busy", {31'd0, mb_busy}, 32'd0);

    // Run 5: fresh macroblock restarts from the first index.
    nz_set = 25'h0001000;
    push_blocks(24);
    push_mb(121 + EXTRA, 25'h0001000, 1'b0);
    start_mb();
    wait_done("run5_done");
    @(negedge clk);

    chk("sb_blk_left", blk_q.size(), 0);
    chk("sb_mb_left", mb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
